// File: rtl/inst_fetch.sv
// Instruction-fetch initiator: owns the PC, drives the synchronous im read port and
// hands decode an instruction stream with stall hold, redirect squash and misalignment fault.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [31:0]      im_addr,
  input  logic [31:0]      im_data,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             inst_valid,
  output logic [31:0]      inst,
  output logic [31:0]      inst_pc,
  output logic             fault,
  output logic [CNT_W-1:0] fetch_cnt
);

  // state    | meaning
  // ST_BOOT  | first cycle after reset: RESET_PC issued, nothing live yet
  // ST_RUN   | streaming: one address issued per cycle
  // ST_FAULT | misaligned redirect seen; frozen until reset
  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic             req_valid_q, req_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic in_fault;
  logic hold;

  assign in_fault = (state_q == ST_FAULT);
  assign hold     = stall & req_valid_q;

  assign inst_valid = req_valid_q & (state_q == ST_RUN) & ~redirect_valid;
  assign inst       = inst_valid ? im_data  : 32'h0;
  assign inst_pc    = inst_valid ? req_pc_q : 32'h0;
  assign fault      = in_fault;
  assign fetch_cnt  = cnt_q;

  // Re-reading req_pc_q while stalled keeps im_data stable for the held instruction.
  always_comb begin
    im_addr = pc_q;
    if (in_fault) begin
      im_addr = req_pc_q;
    end else if (redirect_valid) begin
      im_addr = redirect_pc;
    end else if (hold) begin
      im_addr = req_pc_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = req_valid_q;
    if (!in_fault) begin
      if (redirect_valid) begin
        if (redirect_pc[1:0] == 2'b00) begin
          req_pc_d    = redirect_pc;
          req_valid_d = 1'b1;
          pc_d        = redirect_pc + 32'd4;
          state_d     = ST_RUN;
        end else begin
          req_pc_d    = redirect_pc;
          req_valid_d = 1'b0;
          state_d     = ST_FAULT;
        end
      end else if (!hold) begin
        req_pc_d    = pc_q;
        req_valid_d = 1'b1;
        pc_d        = pc_q + 32'd4;
        state_d     = ST_RUN;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (inst_valid && !stall) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      req_pc_q    <= 32'h0;
      req_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a synchronous im model, a queue-based scoreboard popped by a
// monitor on every accepted instruction, and directed checks on stall/redirect/fault/reset.
module tb_inst_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] im_addr;
  logic [31:0] im_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fault;
  logic [31:0] fetch_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t exp_q[$];

  inst_fetch #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .im_addr        (im_addr),
    .im_data        (im_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .fault          (fault),
    .fetch_cnt      (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_00A0;
      32'h4:   return 32'h0000_00A4;
      32'h8:   return 32'h0000_00A8;
      32'hC:   return 32'h0000_00AC;
      default: return 32'hD000_0000 ^ a;
    endcase
  endfunction

  always @(posedge clk) im_data <= mem_word(im_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.word = mem_word(pc);
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  // Monitor: every accepted instruction must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (inst_valid) begin
        if (!stall) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL unexpected_inst: got pc 0x%08h inst 0x%08h with empty scoreboard", inst_pc, inst);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("mon_inst_pc", inst_pc, e.pc);
            chk("mon_inst", inst, e.word);
          end
        end
      end else begin
        chk("mon_idle_inst", inst, 32'h0);
        chk("mon_idle_pc", inst_pc, 32'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    chk("rst_fetch_cnt", fetch_cnt, 32'h0);
    chk("rst_im_addr", im_addr, 32'h0);
    step(); step();

    // BOOT cycle followed by 0,4,8,C
    rst_n = 1'b1;
    settle();
    chk("boot_inst_valid", {31'h0, inst_valid}, 32'h0);
    chk("boot_im_addr", im_addr, 32'h0);
    push(32'h0); push(32'h4); push(32'h8); push(32'hC);
    for (int i = 0; i < 4; i++) step();

    // redirect back to 0 squashes pc 0x10
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    settle();
    chk("redir0_inst_valid", {31'h0, inst_valid}, 32'h0);
    chk("redir0_im_addr", im_addr, 32'h0);
    chk("cnt_after_four", fetch_cnt, 32'd4);
    push(32'h0); push(32'h4);
    step();
    redirect_valid = 1'b0;

    // stall three cycles while pc 4 is presented
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stall_inst", inst, 32'h0000_00A4);
      chk("stall_inst_pc", inst_pc, 32'h4);
      chk("stall_im_addr", im_addr, 32'h4);
      chk("stall_cnt", fetch_cnt, 32'd5);
      step();
    end
    stall = 1'b0;
    settle();
    chk("unstall_inst_pc", inst_pc, 32'h4);

    // pc 8 follows, then is squashed by redirect to 0
    step();
    chk("after_stall_pc", inst_pc, 32'h8);
    chk("cnt_pc4_once", fetch_cnt, 32'd6);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    settle();
    chk("squash8_inst_valid", {31'h0, inst_valid}, 32'h0);
    chk("squash8_im_addr", im_addr, 32'h0);
    push(32'h0); push(32'h4);
    step();
    redirect_valid = 1'b0;
    step();

    // redirect with stall to 0xC
    step();
    redirect_valid = 1'b1; redirect_pc = 32'hC; stall = 1'b1;
    settle();
    chk("rs_inst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rs_im_addr", im_addr, 32'hC);
    chk("rs_cnt", fetch_cnt, 32'd8);
    push(32'hC);
    step();
    redirect_valid = 1'b0; stall = 1'b0;
    settle();
    chk("rs_target_pc", inst_pc, 32'hC);

    // misaligned redirect
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h6;
    settle();
    chk("mis_inst_valid", {31'h0, inst_valid}, 32'h0);
    chk("mis_fault_early", {31'h0, fault}, 32'h0);
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        redirect_valid = 1'b1; redirect_pc = 32'h0;
      end else begin
        redirect_valid = 1'b0;
      end
      settle();
      chk("fault_flag", {31'h0, fault}, 32'h1);
      chk("fault_inst_valid", {31'h0, inst_valid}, 32'h0);
      chk("fault_cnt", fetch_cnt, 32'd9);
      step();
    end
    redirect_valid = 1'b0;
    chk("fault_im_addr", im_addr, 32'h6);

    // reset clears fault
    rst_n = 1'b0;
    #1;
    chk("frst_fault", {31'h0, fault}, 32'h0);
    chk("frst_cnt", fetch_cnt, 32'h0);
    chk("frst_im_addr", im_addr, 32'h0);
    step(); step();
    rst_n = 1'b1;
    settle();
    chk("boot2_inst_valid", {31'h0, inst_valid}, 32'h0);
    push(32'h0); push(32'h4);
    step(); step(); step();

    // async reset between edges while pc 8 is presented
    #2 rst_n = 1'b0;
    #1;
    chk("arst_inst_valid", {31'h0, inst_valid}, 32'h0);
    chk("arst_inst", inst, 32'h0);
    chk("arst_inst_pc", inst_pc, 32'h0);
    chk("arst_cnt", fetch_cnt, 32'h0);
    chk("arst_im_addr", im_addr, 32'h0);
    step(); step();
    rst_n = 1'b1;
    settle();
    chk("boot3_inst_valid", {31'h0, inst_valid}, 32'h0);
    push(32'h0);
    step();
    settle();
    chk("boot3_first_pc", inst_pc, 32'h0);

    // PC wrap from 0xFFFF_FFFC to 0
    step();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    push(32'hFFFF_FFFC); push(32'h0);
    step();
    redirect_valid = 1'b0;
    settle();
    chk("wrap_im_addr", im_addr, 32'h0);
    step();
    settle();
    chk("wrap_pc", inst_pc, 32'h0);
    chk("wrap_cnt", fetch_cnt, 32'd2);
    step();
    rst_n = 1'b0;
    step();

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
